// File: rtl/ddr_req_arbiter.sv
// Four-way DDR command arbiter: one burst outstanding, grant held to completion, watchdog abort.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise fixed store > jmp > data_rd > isa.
module ddr_req_arbiter #(
  parameter int unsigned DDR_ADDR_WIDTH   = 28,
  parameter int unsigned DATA_CACHE_DEPTH = 16,
  parameter int unsigned TIMEOUT_CYCLES   = 1023
) (
  input  logic                      mem_clk,
  input  logic                      rst_n,
  input  logic                      ddr_rdy,
  input  logic                      isa_req,
  input  logic [DDR_ADDR_WIDTH-1:0] isa_addr,
  input  logic [9:0]                isa_len,
  input  logic                      data_rd_req,
  input  logic [DDR_ADDR_WIDTH-1:0] data_rd_addr,
  input  logic                      jmp_req,
  input  logic [DDR_ADDR_WIDTH-1:0] jmp_addr,
  input  logic                      store_req,
  input  logic [DDR_ADDR_WIDTH-1:0] store_addr,
  input  logic                      cmd_ack,
  input  logic                      cmd_done,
  output logic                      cmd_valid,
  output logic [1:0]                cmd_op,
  output logic [DDR_ADDR_WIDTH-1:0] cmd_addr,
  output logic [9:0]                cmd_len,
  output logic [3:0]                grant,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam logic [9:0] DataLen = 10'(DATA_CACHE_DEPTH + 1);
  localparam logic [9:0] WdLimit = 10'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone, StRelease} state_e;

  state_e                    state_q, state_d;
  logic                      cmd_valid_q, cmd_valid_d;
  logic [1:0]                cmd_op_q, cmd_op_d;
  logic [DDR_ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [9:0]                cmd_len_q, cmd_len_d;
  logic [3:0]                grant_q, grant_d;
  logic                      timeout_err_q, timeout_err_d;
  logic [9:0]                wd_cnt_q, wd_cnt_d;
  logic                      to_release;

  logic [3:0]                elig;
  logic                      win_valid;
  logic [1:0]                win_idx;
  logic [DDR_ADDR_WIDTH-1:0] win_addr;
  logic [9:0]                win_len;

  // Bit index matches cmd_op encoding.
  assign elig = {store_req, jmp_req, data_rd_req, isa_req && (isa_len != 10'd0)};

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] rr_idx;

  // Scan from the farthest offset down so the pointer position is assigned last and wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    rr_idx    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      rr_idx = rr_ptr_q + 2'(i);
      if (elig[rr_idx]) begin
        win_valid = 1'b1;
        win_idx   = rr_idx;
      end
    end
  end
`else
  always_comb begin
    win_valid = |elig;
    win_idx   = 2'd0;
    if (elig[3]) begin
      win_idx = 2'd3;
    end else if (elig[2]) begin
      win_idx = 2'd2;
    end else if (elig[1]) begin
      win_idx = 2'd1;
    end
  end
`endif

  always_comb begin
    win_addr = isa_addr;
    win_len  = isa_len;
    unique case (win_idx)
      2'd0: begin
        win_addr = isa_addr;
        win_len  = isa_len;
      end
      2'd1: begin
        win_addr = data_rd_addr;
        win_len  = DataLen;
      end
      2'd2: begin
        win_addr = jmp_addr;
        win_len  = 10'd1;
      end
      2'd3: begin
        win_addr = store_addr;
        win_len  = DataLen;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_op_d      = cmd_op_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_len_d     = cmd_len_q;
    grant_d       = grant_q;
    timeout_err_d = timeout_err_q;
    wd_cnt_d      = wd_cnt_q;
    to_release    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_d      = rr_ptr_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (ddr_rdy && win_valid) begin
          cmd_op_d    = win_idx;
          cmd_addr_d  = win_addr;
          cmd_len_d   = win_len;
          grant_d     = 4'b0001 << win_idx;
          cmd_valid_d = 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (cmd_ack) begin
          cmd_valid_d = 1'b0;
          wd_cnt_d    = 10'd0;
          if (cmd_done) begin
            to_release = 1'b1;
          end else begin
            state_d = StWaitDone;
          end
        end
      end
      StWaitDone: begin
        if (cmd_done) begin
          to_release = 1'b1;
        end else if (wd_cnt_q == WdLimit) begin
          timeout_err_d = 1'b1;
          to_release    = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 10'd1;
        end
      end
      StRelease: begin
        grant_d = 4'b0000;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Grant drops on entry to RELEASE so the requester sees it before re-arbitration.
    if (to_release) begin
      state_d  = StRelease;
      grant_d  = 4'b0000;
      wd_cnt_d = 10'd0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_d = cmd_op_q + 2'd1;
`endif
    end
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cmd_valid_q   <= 1'b0;
      cmd_op_q      <= 2'd0;
      cmd_addr_q    <= '0;
      cmd_len_q     <= 10'd0;
      grant_q       <= 4'b0000;
      timeout_err_q <= 1'b0;
      wd_cnt_q      <= 10'd0;
    end else begin
      state_q       <= state_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_op_q      <= cmd_op_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_len_q     <= cmd_len_d;
      grant_q       <= grant_d;
      timeout_err_q <= timeout_err_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 2'd0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  assign cmd_valid   = cmd_valid_q;
  assign cmd_op      = cmd_op_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_len     = cmd_len_q;
  assign grant       = grant_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = timeout_err_q;

endmodule
